uart_word_sender: RTL and testbench

- Transmit-side counterpart of the receive-side 16-bit capture register.
- Accepts a 16-bit word over a valid/ready handshake and serialises it into bytes for the UART transmitter.
- Drives the transmitter's byte write strobe and tracks its busy flag so that exactly one byte is in flight at a time.
- Sits between the system data source and the UART transmitter, clocked by the system clock.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_busy_timer.sv | 32 +++
 rtl/uart_word_sender.sv | 114 +++++++++++
 tb/tb_uart_word_sender.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART word sender: FSM encoding, sync byte, clog2 helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    STROBE     = 3'd2,
    WAIT_START = 3'd3,
    WAIT_END   = 3'd4,
    NEXT       = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/uart_busy_timer.sv
// Saturating cycle counter that flags when the transmitter has not gone busy within LIMIT cycles.
module uart_busy_timer
  import uart_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX_COUNT = W'(LIMIT);

  logic [W-1:0] count;

  // Holds at MAX_COUNT so a stalled transmitter can never wrap the counter back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == MAX_COUNT);

endmodule

// File: rtl/uart_word_sender.sv
// Serialises a WORD_BYTES-wide word into one-at-a-time byte writes for a UART transmitter.
// Optional macro UART_WORD_SENDER_SYNC_HEADER_EN prefixes every word with a sync byte.
module uart_word_sender
  import uart_pkg::*;
#(
  parameter int WORD_BYTES   = 2,
  parameter int MSB_FIRST    = 1,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [7:0]              Tx_DATA,
  output logic                    Tx_WR,
  input  logic                    Tx_BUSY,
  output logic                    done,
  output logic                    timeout_err
);

`ifdef UART_WORD_SENDER_SYNC_HEADER_EN
  localparam int NB = WORD_BYTES + 1;
`else
  localparam int NB = WORD_BYTES;
`endif
  localparam int SW = 8 * NB;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] shift_reg;
  logic [SW-1:0] load_value;
  logic [2:0]    count_reg;
  logic [7:0]    hold_reg;
  logic [7:0]    send_byte;
  logic          timeout_reg;
  logic          expired;
  logic          accept;

  assign accept = word_valid && (state == IDLE);

  // The sync byte sits at whichever end is shifted out first, so it always leads the word.
`ifdef UART_WORD_SENDER_SYNC_HEADER_EN
  assign load_value = (MSB_FIRST != 0) ? {SYNC_BYTE, word_in} : {word_in, SYNC_BYTE};
`else
  assign load_value = word_in;
`endif

  assign send_byte = (MSB_FIRST != 0) ? shift_reg[SW-1 -: 8] : shift_reg[7:0];

  uart_busy_timer #(
    .LIMIT(BUSY_TIMEOUT)
  ) u_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == STROBE),
    .enable (state == WAIT_START),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = LOAD;
      LOAD:       if (!Tx_BUSY) state_next = STROBE;
      STROBE:     state_next = WAIT_START;
      WAIT_START: begin
        if (Tx_BUSY)      state_next = WAIT_END;
        else if (expired) state_next = NEXT;
      end
      WAIT_END:   if (!Tx_BUSY) state_next = NEXT;
      NEXT:       state_next = (count_reg == 3'd1) ? IDLE : LOAD;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg   <= '0;
      count_reg   <= '0;
      hold_reg    <= 8'h00;
      timeout_reg <= 1'b0;
    end else begin
      if (accept) begin
        shift_reg   <= load_value;
        count_reg   <= 3'(NB);
        timeout_reg <= 1'b0;
      end
      if (state == STROBE) hold_reg <= send_byte;
      if ((state == WAIT_START) && !Tx_BUSY && expired) timeout_reg <= 1'b1;
      if (state == NEXT) begin
        shift_reg <= (MSB_FIRST != 0) ? (shift_reg << 8) : (shift_reg >> 8);
        count_reg <= count_reg - 3'd1;
      end
    end
  end

  // Outside the active byte window Tx_DATA shows the last byte actually strobed.
  always_comb begin
    word_ready  = (state == IDLE);
    Tx_WR       = (state == STROBE);
    done        = (state == NEXT) && (count_reg == 3'd1);
    timeout_err = timeout_reg;
    Tx_DATA     = hold_reg;
    if ((state == LOAD) || (state == STROBE) || (state == WAIT_START) || (state == WAIT_END))
      Tx_DATA = send_byte;
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed bench for uart_word_sender: an MSB-first and an LSB-first instance behind one transmitter model.
module tb_uart_word_sender;

`ifdef UART_WORD_SENDER_SYNC_HEADER_EN
  localparam int NPW = 3;
`else
  localparam int NPW = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        stuck;
  logic [15:0] word_in;
  logic        word_valid;
  logic        busy;

  logic       ready0, ready1, wr0, wr1, done0, done1, terr0, terr1;
  logic [7:0] data0, data1;
  logic       m_ready, m_wr, m_done, m_terr;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  uart_word_sender #(.WORD_BYTES(2), .MSB_FIRST(1), .BUSY_TIMEOUT(15)) u_msb (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid && !sel),
    .word_ready(ready0), .Tx_DATA(data0), .Tx_WR(wr0), .Tx_BUSY(busy && !sel),
    .done(done0), .timeout_err(terr0)
  );

  uart_word_sender #(.WORD_BYTES(2), .MSB_FIRST(0), .BUSY_TIMEOUT(15)) u_lsb (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid && sel),
    .word_ready(ready1), .Tx_DATA(data1), .Tx_WR(wr1), .Tx_BUSY(busy && sel),
    .done(done1), .timeout_err(terr1)
  );

  assign m_ready = sel ? ready1 : ready0;
  assign m_wr    = sel ? wr1    : wr0;
  assign m_done  = sel ? done1  : done0;
  assign m_terr  = sel ? terr1  : terr0;
  assign m_data  = sel ? data1  : data0;

  int         cyc = 0;
  int         busy_cnt = 0;
  int         nbytes = 0;
  int         nacc = 0;
  int         ndone = 0;
  int         nwr_busy = 0;
  int         nready_bad = 0;
  int         terr_cyc = 0;
  logic       terr_prev = 1'b0;
  logic       in_word = 1'b0;
  logic [7:0] byte_log [64];
  int         wr_cyc   [64];
  int         acc_cyc  [16];
  int         done_cyc [16];

  assign busy = (busy_cnt != 0);

  // Transmitter model (busy for 10 cycles after each strobe unless stuck) plus event monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      busy_cnt <= 0;
      in_word  <= 1'b0;
    end else begin
      if (m_wr && !stuck)    busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (m_wr) begin
        if (nbytes < 64) begin
          byte_log[nbytes] <= m_data;
          wr_cyc[nbytes]   <= cyc;
        end
        nbytes <= nbytes + 1;
        if (busy) nwr_busy <= nwr_busy + 1;
      end
      if (word_valid && m_ready) begin
        if (nacc < 16) acc_cyc[nacc] <= cyc;
        nacc    <= nacc + 1;
        in_word <= 1'b1;
      end else if (m_done) begin
        in_word <= 1'b0;
      end
      if (in_word && m_ready) nready_bad <= nready_bad + 1;
      if (m_done) begin
        if (ndone < 16) done_cyc[ndone] <= cyc;
        ndone <= ndone + 1;
      end
      if (m_terr && !terr_prev) terr_cyc <= cyc;
      terr_prev <= m_terr;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 100 && nacc < target; i++) @(negedge clk);
    chk("accept_wait", 32'(nacc >= target), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && ndone < target; i++) @(negedge clk);
    chk("done_wait", 32'(ndone >= target), 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    int target;
    target = nacc + 1;
    @(negedge clk);
    word_in    = w;
    word_valid = 1'b1;
    wait_acc(target);
    word_valid = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [15:0] w, input bit msb);
    int k;
    k = base;
`ifdef UART_WORD_SENDER_SYNC_HEADER_EN
    chk({tag, "_sync"}, 32'(byte_log[k]), 32'h0000_00A5);
    k++;
`endif
    chk({tag, "_b0"}, 32'(byte_log[k]),     32'(msb ? w[15:8] : w[7:0]));
    chk({tag, "_b1"}, 32'(byte_log[k + 1]), 32'(msb ? w[7:0] : w[15:8]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_bytes, b_acc, b_done, b_bad, d;

    // Reset and idle
    reset = 1'b0; sel = 1'b0; stuck = 1'b0; word_in = 16'h0000; word_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_wr",    32'(wr0),    32'd0);
    chk("rst_data",  32'(data0),  32'h00);
    chk("rst_done",  32'(done0),  32'd0);
    chk("rst_terr",  32'(terr0),  32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ready",  32'(ready0), 32'd1);
    chk("idle_data",   32'(data0),  32'h00);
    chk("idle_nbytes", 32'(nbytes), 32'd0);

    // MSB-first word
    b_bytes = nbytes; b_acc = nacc; b_done = ndone;
    send(16'h4DE3);
    wait_done(b_done + 1);
    repeat (3) @(negedge clk);
    check_bytes("msb_4de3", b_bytes, 16'h4DE3, 1'b1);
    chk("msb_nbytes",  32'(nbytes - b_bytes), 32'(NPW));
    chk("msb_ndone",   32'(ndone - b_done), 32'd1);
    chk("msb_latency", 32'(wr_cyc[b_bytes] - acc_cyc[b_acc]), 32'd2);
    chk("msb_hold",    32'(data0), 32'hE3);
    chk("msb_ready",   32'(ready0), 32'd1);

    // LSB-first word on the second instance
    @(negedge clk);
    sel = 1'b1;
    b_bytes = nbytes; b_done = ndone;
    send(16'h4DE3);
    wait_done(b_done + 1);
    repeat (2) @(negedge clk);
    check_bytes("lsb_4de3", b_bytes, 16'h4DE3, 1'b0);
    chk("lsb_nbytes", 32'(nbytes - b_bytes), 32'(NPW));
    chk("lsb_ndone",  32'(ndone - b_done), 32'd1);
    chk("lsb_hold",   32'(data1), 32'h4D);

    // Back-to-back words with word_valid held high
    @(negedge clk);
    sel = 1'b0;
    b_bytes = nbytes; b_acc = nacc; b_done = ndone; b_bad = nready_bad;
    word_in = 16'hFFFF; word_valid = 1'b1;
    wait_acc(b_acc + 1);
    word_in = 16'h0001;
    wait_acc(b_acc + 2);
    word_valid = 1'b0;
    wait_done(b_done + 2);
    repeat (2) @(negedge clk);
    check_bytes("b2b_ffff", b_bytes, 16'hFFFF, 1'b1);
    check_bytes("b2b_0001", b_bytes + NPW, 16'h0001, 1'b1);
    chk("b2b_nbytes",    32'(nbytes - b_bytes), 32'(2 * NPW));
    chk("b2b_ndone",     32'(ndone - b_done), 32'd2);
    chk("b2b_ready_low", 32'(nready_bad - b_bad), 32'd0);
    chk("b2b_gap",       32'(acc_cyc[b_acc + 1] - done_cyc[b_done]), 32'd1);

    // Transmitter never goes busy: every byte times out
    stuck = 1'b1;
    b_bytes = nbytes; b_done = ndone;
    send(16'h1234);
    wait_done(b_done + 1);
    repeat (2) @(negedge clk);
    d = terr_cyc - wr_cyc[b_bytes];
    chk("to_window",  32'(d >= 15 && d <= 17), 32'd1);
    chk("to_sticky",  32'(terr0), 32'd1);
    chk("to_ndone",   32'(ndone - b_done), 32'd1);
    chk("to_nbytes",  32'(nbytes - b_bytes), 32'(NPW));
    check_bytes("to_1234", b_bytes, 16'h1234, 1'b1);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_held_idle", 32'(terr0), 32'd1);
    b_bytes = nbytes; b_done = ndone;
    send(16'h5678);
    chk("to_cleared", 32'(terr0), 32'd0);
    wait_done(b_done + 1);
    repeat (2) @(negedge clk);
    check_bytes("after_to_5678", b_bytes, 16'h5678, 1'b1);
    chk("no_wr_while_busy", 32'(nwr_busy), 32'd0);

    // Reset asserted while the second byte is being strobed
    b_bytes = nbytes; b_done = ndone;
    send(16'hABCD);
    for (int i = 0; i < 200 && !(m_wr && nbytes >= b_bytes + 1); i++) @(negedge clk);
    chk("mid_strobe_seen", 32'(m_wr && nbytes >= b_bytes + 1), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_wr",    32'(wr0),    32'd0);
    chk("mid_ready", 32'(ready0), 32'd1);
    chk("mid_data",  32'(data0),  32'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_nbytes",    32'(nbytes - b_bytes), 32'd1);
    chk("mid_ndone",     32'(ndone - b_done), 32'd0);
    chk("mid_ready_rel", 32'(ready0), 32'd1);
    chk("mid_wr_rel",    32'(wr0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
